register_dump_unit: RTL and testbench
=====================================

REGISTER_DUMP_UNIT -- requirements
Module: register_dump_unit

Interface
REQ-001 Ports SHALL be, one per line (name, direction, width, meaning); one clock, reset asynchronous and active-high:
- clock  input  1  sole clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- dumpRequest  input  1  start a full register dump; sampled only in IDLE.
- readAddress  output  5  register index presented to a register-file read port.
- readData  input  32  combinational read data for readAddress, same cycle.
- byteOut  output  8  serialized dump byte.
- byteValid  output  1  byteOut holds a valid byte.
- byteReady  input  1  consumer accepts byteOut on an edge where byteValid && byteReady.
- busy  output  1  high from request acceptance until DONE is exited.
- done  output  1  one-cycle pulse after the final byte is accepted.

Function
REQ-002 States SHALL be IDLE, LOAD, SEND, CHECKSUM (only when configured) and DONE.
REQ-003 IDLE: busy=0, byteValid=0; dumpRequest high at an edge -> LOAD, register index=0, byte count=0.
REQ-004 LOAD: readAddress=index; at the next edge readData SHALL be captured into a 32-bit shift register -> SEND; byteValid=0 during LOAD.
REQ-005 SEND: byteValid=1, byteOut=shift[7:0]; bytes SHALL go out little-endian, 4 per register.
REQ-006 On an edge with byteValid && byteReady: shift right 8 bits, byte count +1; the 4th accept of a register SHALL go to LOAD with index+1, or, if index==31, to CHECKSUM (configured) or DONE.
REQ-007 While byteValid && !byteReady, byteOut SHALL be held stable and no state SHALL advance; byteValid SHALL never drop without an accept.
REQ-008 Index SHALL NOT wrap: after register 31 the dump ends. Each dump is exactly 128 data bytes, registers 0..31 in order.
REQ-009 DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
REQ-010 dumpRequest SHALL be ignored outside IDLE, including in DONE. No request queueing.
REQ-011 No snapshot: each register is read at its own LOAD cycle. Writes landing before that cycle are visible; later writes are not.
REQ-012 Timing, byteReady held high, request sampled at edge N:
- register k captured at edge N+1+5k;
- its bytes accepted at edges N+2+5k .. N+5+5k;
- last data byte accepted at edge N+160.
REQ-013 readAddress SHALL hold the current index outside LOAD. It reads 0 in IDLE.

Reset
REQ-014 Reset SHALL force the following state, asynchronously:
- IDLE, index=0, byte count=0;
- shift register=0, checksum accumulator=0;
- readAddress=0, byteOut=0, byteValid=0, busy=0, done=0.
REQ-015 Reset mid-dump SHALL abort immediately with no done pulse. The next dump SHALL restart at register 0.

Configuration
REQ-016 Macro REGISTER_DUMP_CHECKSUM_EN:
- Defined:
  - an 8-bit XOR of all 128 data bytes SHALL accumulate as bytes are accepted;
  - the accumulator clears on request acceptance;
  - CHECKSUM presents it as byte 129 with the same handshake rules;
  - its accept -> DONE, so done follows edge N+161 at full rate.
- Undefined: no CHECKSUM state or accumulator logic; dump is 128 bytes; done follows edge N+160.

Verification
REQ-017 Scenarios:
- Registers preloaded x[i]=0x01010101*i (x0=0), byteReady=1, pulse dumpRequest -> 128 bytes 00 00 00 00, 01 01 01 01, ... 1F 1F 1F 1F, ending at edge N+160. Without macro: done one cycle after N+160. With macro: 129th byte=0x00 (XOR of 0x00..0x1F, each 4 times), done one cycle after N+161.
- x5=0xDEADBEEF, byteReady toggled pseudo-randomly -> bytes 20-23 = EF BE AD DE; byteOut/byteValid stable during every stall; total byte count 128 (or 129).
- dumpRequest held high for 300 cycles -> exactly one dump per IDLE entry; second dump starts only after done; requests during busy produce nothing extra.
- Reset asserted after the 50th accepted byte -> byteValid=0, busy=0 asynchronously; no done pulse; next request starts again at register 0, byte 00.
- x31 written 0x12345678 while register 3 is streaming -> dump shows 78 56 34 12 for register 31.
- With macro, x1=0x000000FF only, others 0 -> checksum byte 0xFF.

Source files
------------

// File: rtl/register_dump_unit.sv
`default_nettype none
// ============================================================================
// Module      : register_dump_unit
// Description : Streams registers 0..31 of a register file out as
//               little-endian bytes over a valid/ready byte channel.
//               Optional trailing XOR checksum byte, enabled by defining
//               the macro REGISTER_DUMP_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module register_dump_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        dumpRequest,
    output logic [4:0]  readAddress,
    input  logic [31:0] readData,
    output logic [7:0]  byteOut,
    output logic        byteValid,
    input  logic        byteReady,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_LOAD     = 3'd1;
    localparam logic [2:0] c_ST_SEND     = 3'd2;
    localparam logic [2:0] c_ST_DONE     = 3'd3;
`ifdef REGISTER_DUMP_CHECKSUM_EN
    localparam logic [2:0] c_ST_CHECKSUM = 3'd4;
`endif
    localparam logic [4:0] c_LAST_INDEX  = 5'd31;
    localparam logic [1:0] c_LAST_BYTE   = 2'd3;

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [4:0]  r_index;
    logic [1:0]  r_bytecnt;
    logic [31:0] r_shift;
    logic        w_accept;
    logic        w_reg_finished;
`ifdef REGISTER_DUMP_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    assign w_accept       = byteValid && byteReady;
    assign w_reg_finished = (r_state == c_ST_SEND) && w_accept && (r_bytecnt == c_LAST_BYTE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (dumpRequest) begin
                    w_state_next = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_state_next = c_ST_SEND;
            end
            c_ST_SEND: begin
                if (w_reg_finished) begin
                    if (r_index != c_LAST_INDEX) begin
                        w_state_next = c_ST_LOAD;
                    end else begin
`ifdef REGISTER_DUMP_CHECKSUM_EN
                        w_state_next = c_ST_CHECKSUM;
`else
                        w_state_next = c_ST_DONE;
`endif
                    end
                end
            end
`ifdef REGISTER_DUMP_CHECKSUM_EN
            c_ST_CHECKSUM: begin
                if (byteReady) begin
                    w_state_next = c_ST_DONE;
                end
            end
`endif
            c_ST_DONE: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Index advances only on a register's final byte and never past 31.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_index   <= 5'd0;
            r_bytecnt <= 2'd0;
            r_shift   <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (dumpRequest) begin
                        r_index   <= 5'd0;
                        r_bytecnt <= 2'd0;
                    end
                end
                c_ST_LOAD: begin
                    r_shift   <= readData;
                    r_bytecnt <= 2'd0;
                end
                c_ST_SEND: begin
                    if (w_accept) begin
                        r_shift   <= {8'd0, r_shift[31:8]};
                        r_bytecnt <= r_bytecnt + 2'd1;
                        if ((r_bytecnt == c_LAST_BYTE) && (r_index != c_LAST_INDEX)) begin
                            r_index <= r_index + 5'd1;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_index <= 5'd0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef REGISTER_DUMP_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_csum <= 8'd0;
        end else if ((r_state == c_ST_IDLE) && dumpRequest) begin
            r_csum <= 8'd0;
        end else if ((r_state == c_ST_SEND) && w_accept) begin
            r_csum <= r_csum ^ r_shift[7:0];
        end
    end
`endif

    always_comb begin
        readAddress = r_index;
        busy        = (r_state != c_ST_IDLE);
        done        = (r_state == c_ST_DONE);
        byteValid   = 1'b0;
        byteOut     = 8'd0;
        if (r_state == c_ST_SEND) begin
            byteValid = 1'b1;
            byteOut   = r_shift[7:0];
        end
`ifdef REGISTER_DUMP_CHECKSUM_EN
        if (r_state == c_ST_CHECKSUM) begin
            byteValid = 1'b1;
            byteOut   = r_csum;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_register_dump_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_dump_unit
// Description : Self-checking bench for register_dump_unit against a
//               byte-list reference model (honours REGISTER_DUMP_CHECKSUM_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_dump_unit;

`ifdef REGISTER_DUMP_CHECKSUM_EN
    localparam int c_NBYTES    = 129;
    localparam int c_DONE_EDGE = 161;
`else
    localparam int c_NBYTES    = 128;
    localparam int c_DONE_EDGE = 160;
`endif
    localparam int c_DATA = 128;

    logic        clock = 1'b0;
    logic        reset;
    logic        dumpRequest;
    logic [4:0]  readAddress;
    logic [31:0] readData;
    logic [7:0]  byteOut;
    logic        byteValid;
    logic        byteReady;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    logic [7:0]  q_exp [$];
    logic [7:0]  q_got [$];
    int          done_edge;
    int          last_acc_edge;
    int          n_done;
    bit          timed_out;
    int          checks   = 0;
    int          failures = 0;

    assign readData = regs[readAddress];

    always #5 clock = ~clock;

    register_dump_unit dut (
        .clock       (clock),
        .reset       (reset),
        .dumpRequest (dumpRequest),
        .readAddress (readAddress),
        .readData    (readData),
        .byteOut     (byteOut),
        .byteValid   (byteValid),
        .byteReady   (byteReady),
        .busy        (busy),
        .done        (done)
    );

    // Reference: every register, little-endian, then the XOR of all data bytes.
    function automatic void build_expected();
        logic [7:0] x;
        x = 8'd0;
        q_exp.delete();
        for (int k = 0; k < 32; k++) begin
            for (int b = 0; b < 4; b++) begin
                q_exp.push_back(regs[k][8*b +: 8]);
                x = x ^ regs[k][8*b +: 8];
            end
        end
`ifdef REGISTER_DUMP_CHECKSUM_EN
        q_exp.push_back(x);
`endif
    endfunction

    function automatic void set_ramp();
        for (int k = 0; k < 32; k++) regs[k] = 32'h01010101 * k;
    endfunction

    task automatic run_dump(input bit rand_ready, input int wr_at,
                            input logic [31:0] wr_val, input int abort_at);
        int e;
        int acc;
        bit stall;
        bit wrote;
        logic [7:0] prev_b;
        e = 0; acc = 0; stall = 0; wrote = 0; prev_b = 8'd0;
        q_got.delete();
        done_edge = -1; last_acc_edge = -1; n_done = 0; timed_out = 0;
        @(negedge clock);
        dumpRequest = 1'b1;
        byteReady   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        dumpRequest = 1'b0;
        while (1) begin
            if (e > 3000) begin
                timed_out = 1;
                break;
            end
            byteReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall) begin
                checks++;
                if (byteValid !== 1'b1 || byteOut !== prev_b) begin
                    failures++;
                    $display("FAIL stall_hold edge=%0d valid=%b byte=%h required valid=1 byte=%h",
                             e, byteValid, byteOut, prev_b);
                end
            end
            if (done === 1'b1) begin
                n_done++;
                done_edge = e;
            end
            if (done_edge >= 0 && busy === 1'b0) break;
            if (byteValid === 1'b1 && byteReady === 1'b1) begin
                q_got.push_back(byteOut);
                acc++;
                if (acc == c_DATA) last_acc_edge = e + 1;
            end
            stall  = (byteValid === 1'b1) && (byteReady !== 1'b1);
            prev_b = byteOut;
            if (!wrote && wr_at >= 0 && acc == wr_at) begin
                regs[31] = wr_val;
                wrote = 1;
            end
            if (abort_at > 0 && acc == abort_at) begin
                @(posedge clock);
                #2 reset = 1'b1;
                #1;
                checks++;
                if (byteValid !== 1'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_async valid=%b busy=%b required 0 0", byteValid, busy);
                end
                repeat (3) begin
                    @(negedge clock);
                    checks++;
                    if (done !== 1'b0 || readAddress !== 5'd0) begin
                        failures++;
                        $display("FAIL abort_quiet done=%b addr=%0d required 0 0", done, readAddress);
                    end
                end
                reset = 1'b0;
                return;
            end
            @(posedge clock);
            e++;
            @(negedge clock);
        end
        if (timed_out) begin
            checks++;
            failures++;
            $display("FAIL dump_timeout edges=%0d bytes=%0d required completion", e, q_got.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; dumpRequest = 1'b0; byteReady = 1'b0;
        for (int k = 0; k < 32; k++) regs[k] = 32'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({readAddress, byteOut, byteValid, busy, done} !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs got addr=%0d byte=%h v=%b busy=%b done=%b required all 0",
                     readAddress, byteOut, byteValid, busy, done);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || byteValid !== 1'b0 || readAddress !== 5'd0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b v=%b addr=%0d required 0 0 0", busy, byteValid, readAddress);
        end
    endtask

    task automatic test_ordered_dump();
        set_ramp();
        build_expected();
        run_dump(1'b0, -1, 32'd0, 0);
        checks++;
        if (q_got.size() != c_NBYTES) begin
            failures++;
            $display("FAIL ordered_count got=%0d required=%0d", q_got.size(), c_NBYTES);
        end
        for (int i = 0; i < c_NBYTES && i < q_got.size(); i++) begin
            checks++;
            if (q_got[i] !== q_exp[i]) begin
                failures++;
                $display("FAIL ordered_byte%0d got=%h required=%h", i, q_got[i], q_exp[i]);
            end
        end
        checks++;
        if (last_acc_edge != 160) begin
            failures++;
            $display("FAIL last_data_edge got=%0d required=160", last_acc_edge);
        end
        checks++;
        if (done_edge != c_DONE_EDGE || n_done != 1) begin
            failures++;
            $display("FAIL done_timing edge=%0d pulses=%0d required edge=%0d pulses=1",
                     done_edge, n_done, c_DONE_EDGE);
        end
        checks++;
        if (readAddress !== 5'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_dump addr=%0d busy=%b required 0 0", readAddress, busy);
        end
    endtask

    task automatic test_random_stall();
        for (int k = 0; k < 32; k++) regs[k] = $urandom;
        regs[5] = 32'hDEADBEEF;
        build_expected();
        run_dump(1'b1, -1, 32'd0, 0);
        checks++;
        if (q_got.size() != c_NBYTES || n_done != 1) begin
            failures++;
            $display("FAIL stall_count got=%0d done=%0d required=%0d 1", q_got.size(), n_done, c_NBYTES);
        end
        if (q_got.size() >= 24) begin
            checks++;
            if ({q_got[23], q_got[22], q_got[21], q_got[20]} !== 32'hDEADBEEF) begin
                failures++;
                $display("FAIL stall_reg5 got=%h%h%h%h required=deadbeef", q_got[23], q_got[22], q_got[21], q_got[20]);
            end
        end
        for (int i = 0; i < c_NBYTES && i < q_got.size(); i++) begin
            checks++;
            if (q_got[i] !== q_exp[i]) begin
                failures++;
                $display("FAIL stall_byte%0d got=%h required=%h", i, q_got[i], q_exp[i]);
            end
        end
    endtask

    task automatic test_hold_request();
        int e;
        int dones;
        int rises;
        bit prev_busy;
        logic [7:0] got [$];
        e = 0; dones = 0; rises = 0; prev_busy = 0;
        set_ramp();
        build_expected();
        @(negedge clock);
        dumpRequest = 1'b1;
        byteReady   = 1'b1;
        while (e < 1000) begin
            @(posedge clock);
            e++;
            @(negedge clock);
            if (e == 300) dumpRequest = 1'b0;
            if (busy === 1'b1 && !prev_busy) begin
                rises++;
                checks++;
                if (dones != rises - 1) begin
                    failures++;
                    $display("FAIL hold_start_before_done start=%0d dones=%0d required=%0d", rises, dones, rises - 1);
                end
            end
            if (done === 1'b1) dones++;
            if (byteValid === 1'b1 && byteReady === 1'b1) got.push_back(byteOut);
            prev_busy = (busy === 1'b1);
            if (e > 300 && busy === 1'b0) break;
        end
        checks++;
        if (rises != 2 || dones != 2 || got.size() != 2 * c_NBYTES) begin
            failures++;
            $display("FAIL hold_dumps starts=%0d dones=%0d bytes=%0d required 2 2 %0d",
                     rises, dones, got.size(), 2 * c_NBYTES);
        end
        for (int i = 0; i < got.size() && i < 2 * c_NBYTES; i++) begin
            checks++;
            if (got[i] !== q_exp[i % c_NBYTES]) begin
                failures++;
                $display("FAIL hold_byte%0d got=%h required=%h", i, got[i], q_exp[i % c_NBYTES]);
            end
        end
    endtask

    task automatic test_reset_abort();
        set_ramp();
        build_expected();
        run_dump(1'b0, -1, 32'd0, 50);
        checks++;
        if (n_done != 0 || q_got.size() != 50) begin
            failures++;
            $display("FAIL abort_progress done=%0d bytes=%0d required 0 50", n_done, q_got.size());
        end
        run_dump(1'b0, -1, 32'd0, 0);
        checks++;
        if (q_got.size() != c_NBYTES || n_done != 1) begin
            failures++;
            $display("FAIL restart_count got=%0d done=%0d required=%0d 1", q_got.size(), n_done, c_NBYTES);
        end
        for (int i = 0; i < c_NBYTES && i < q_got.size(); i++) begin
            checks++;
            if (q_got[i] !== q_exp[i]) begin
                failures++;
                $display("FAIL restart_byte%0d got=%h required=%h", i, q_got[i], q_exp[i]);
            end
        end
    endtask

    task automatic test_late_write();
        set_ramp();
        run_dump(1'b0, 13, 32'h12345678, 0);
        build_expected();
        checks++;
        if (q_got.size() != c_NBYTES) begin
            failures++;
            $display("FAIL late_count got=%0d required=%0d", q_got.size(), c_NBYTES);
        end else begin
            checks++;
            if ({q_got[127], q_got[126], q_got[125], q_got[124]} !== 32'h12345678) begin
                failures++;
                $display("FAIL late_reg31 got=%h%h%h%h required=12345678",
                         q_got[127], q_got[126], q_got[125], q_got[124]);
            end
            for (int i = 0; i < c_NBYTES; i++) begin
                checks++;
                if (q_got[i] !== q_exp[i]) begin
                    failures++;
                    $display("FAIL late_byte%0d got=%h required=%h", i, q_got[i], q_exp[i]);
                end
            end
        end
    endtask

    task automatic test_checksum_single();
        for (int k = 0; k < 32; k++) regs[k] = 32'd0;
        regs[1] = 32'h000000FF;
        build_expected();
        run_dump(1'b1, -1, 32'd0, 0);
        checks++;
        if (q_got.size() != c_NBYTES) begin
            failures++;
            $display("FAIL csum_count got=%0d required=%0d", q_got.size(), c_NBYTES);
        end else begin
            checks++;
            if (q_got[c_NBYTES-1] !== q_exp[c_NBYTES-1] || q_got[4] !== 8'hFF) begin
                failures++;
                $display("FAIL csum_final got=%h byte4=%h required=%h ff",
                         q_got[c_NBYTES-1], q_got[4], q_exp[c_NBYTES-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ordered_dump();
        test_random_stall();
        test_hold_request();
        test_reset_abort();
        test_late_write();
        test_checksum_single();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
